// File: rtl/dcnn_dram_wpack.sv
// Output-stream writer: packs DW-bit words into PACK-word beats, buffers them
// and emits address/length burst requests followed by the beat data.
module dcnn_dram_wpack #(
    parameter int unsigned DW        = 16,
    parameter int unsigned AW        = 32,
    parameter int unsigned PACK      = 4,
    parameter int unsigned BURST_MAX = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_start,
    input  logic [AW-1:0]                 cfg_base_addr,
    output logic                          busy,
    output logic                          done,
    input  logic                          dram_w_vld,
    output logic                          dram_w_rdy,
    input  logic [DW-1:0]                 dram_w_data,
    input  logic                          dram_w_last,
    output logic                          mem_req_vld,
    input  logic                          mem_req_rdy,
    output logic [AW-1:0]                 mem_req_addr,
    output logic [$clog2(BURST_MAX):0]    mem_req_len,
    output logic                          mem_wd_vld,
    input  logic                          mem_wd_rdy,
    output logic [DW*PACK-1:0]            mem_wd_data,
    output logic [DW*PACK/8-1:0]          mem_wd_strb,
    output logic                          mem_wd_last
);

    localparam int unsigned BW         = DW * PACK;
    localparam int unsigned SW         = BW / 8;
    localparam int unsigned LB         = DW / 8;
    localparam int unsigned LW         = $clog2(BURST_MAX) + 1;
    localparam int unsigned DEPTH      = 2 * BURST_MAX;
    localparam int unsigned PW         = $clog2(DEPTH);
    localparam int unsigned CW         = PW + 1;
    localparam int unsigned IW         = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int unsigned BEAT_BYTES = BW / 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_REQ,
        S_DATA,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [LW-1:0]   len_q, len_d;
    logic [LW-1:0]   beat_q, beat_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [BW-1:0]   pack_q, pack_d;
    logic            last_seen_q, last_seen_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [BW-1:0]   fifo_data_q [DEPTH];
    logic [SW-1:0]   fifo_strb_q [DEPTH];

    logic            w_rdy;
    logic            word_acc;
    logic            beat_push;
    logic            beat_pop;
    logic [BW-1:0]   beat_data;
    logic [SW-1:0]   beat_strb;

    always_comb begin
        busy         = (state_q != S_IDLE);
        done         = (state_q == S_DONE);
        mem_req_vld  = (state_q == S_REQ);
        mem_req_addr = addr_q;
        mem_req_len  = len_q;
        mem_wd_vld   = (state_q == S_DATA);
        mem_wd_last  = mem_wd_vld && (beat_q == len_q - LW'(1));
        mem_wd_data  = mem_wd_vld ? fifo_data_q[rd_ptr_q] : '0;
        mem_wd_strb  = mem_wd_vld ? fifo_strb_q[rd_ptr_q] : '0;
        // Built only from registered state so memory-side ready never reaches the word side.
        w_rdy        = (state_q != S_IDLE) && !last_seen_q && (cnt_q < CW'(DEPTH));
        dram_w_rdy   = w_rdy;
        word_acc     = dram_w_vld && w_rdy;
        beat_push    = word_acc && ((idx_q == IW'(PACK - 1)) || dram_w_last);
        beat_pop     = mem_wd_vld && mem_wd_rdy;
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        beat_d      = beat_q;
        idx_d       = idx_q;
        pack_d      = pack_q;
        last_seen_d = last_seen_q;
        cnt_d       = cnt_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        beat_data   = pack_q;
        beat_strb   = '0;

        for (int unsigned i = 0; i < PACK; i++) begin
            if (IW'(i) == idx_q) beat_data[i*DW +: DW] = dram_w_data;
            if (IW'(i) <= idx_q) beat_strb[i*LB +: LB] = '1;
        end

        if (word_acc) begin
            if (beat_push) begin
                pack_d = '0;
                idx_d  = '0;
            end else begin
                pack_d = beat_data;
                idx_d  = idx_q + IW'(1);
            end
            if (dram_w_last) last_seen_d = 1'b1;
        end

        if (beat_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (beat_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({beat_push, beat_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: ;
        endcase

        case (state_q)
            S_IDLE: begin
                last_seen_d = 1'b0;
                if (cfg_start) begin
                    addr_d  = cfg_base_addr;
                    state_d = S_COLLECT;
                end
            end
            // Decision uses the post-push count so REQ rises the cycle after the completing word.
            S_COLLECT: begin
                if (cnt_d >= CW'(BURST_MAX)) begin
                    len_d   = LW'(BURST_MAX);
                    state_d = S_REQ;
                end else if (last_seen_d && (cnt_d != '0)) begin
                    len_d   = LW'(cnt_d);
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_req_rdy) begin
                    addr_d  = addr_q + AW'(len_q) * AW'(BEAT_BYTES);
                    beat_d  = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (beat_pop) begin
                    beat_d = beat_q + LW'(1);
                    if (beat_q == len_q - LW'(1)) begin
                        state_d = (last_seen_d && (cnt_d == '0)) ? S_DONE : S_COLLECT;
                    end
                end
            end
            S_DONE: begin
                last_seen_d = 1'b0;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            idx_q       <= '0;
            pack_q      <= '0;
            last_seen_q <= 1'b0;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            idx_q       <= idx_d;
            pack_q      <= pack_d;
            last_seen_q <= last_seen_d;
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (beat_push) begin
            fifo_data_q[wr_ptr_q] <= beat_data;
            fifo_strb_q[wr_ptr_q] <= beat_strb;
        end
    end

endmodule

// File: tb/tb_dcnn_dram_wpack.sv
// Directed bench for dcnn_dram_wpack: word driver, memory-side monitor and
// hand-computed expectations checked with immediate assertions.
module tb_dcnn_dram_wpack;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_start = 1'b0;
    logic [31:0] cfg_base_addr = '0;
    logic        busy, done;
    logic        dram_w_vld = 1'b0;
    logic        dram_w_rdy;
    logic [15:0] dram_w_data = '0;
    logic        dram_w_last = 1'b0;
    logic        mem_req_vld;
    logic        mem_req_rdy = 1'b1;
    logic [31:0] mem_req_addr;
    logic [4:0]  mem_req_len;
    logic        mem_wd_vld;
    logic        mem_wd_rdy = 1'b1;
    logic [63:0] mem_wd_data;
    logic [7:0]  mem_wd_strb;
    logic        mem_wd_last;

    dcnn_dram_wpack #(.DW(16), .AW(32), .PACK(4), .BURST_MAX(16)) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_base_addr(cfg_base_addr),
        .busy(busy), .done(done),
        .dram_w_vld(dram_w_vld), .dram_w_rdy(dram_w_rdy), .dram_w_data(dram_w_data),
        .dram_w_last(dram_w_last),
        .mem_req_vld(mem_req_vld), .mem_req_rdy(mem_req_rdy), .mem_req_addr(mem_req_addr),
        .mem_req_len(mem_req_len),
        .mem_wd_vld(mem_wd_vld), .mem_wd_rdy(mem_wd_rdy), .mem_wd_data(mem_wd_data),
        .mem_wd_strb(mem_wd_strb), .mem_wd_last(mem_wd_last)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [4:0]  len;
    } req_t;

    req_t        req_q[$];
    logic [63:0] bdata_q[$];
    logic [7:0]  bstrb_q[$];
    logic        blast_q[$];
    int          words_acc = 0;
    int          done_cnt = 0;
    int          proto_err = 0;
    int          n_assert = 0;
    int          n_fail = 0;

    // Memory-side monitor: records handshakes and flags protocol breaks.
    initial begin
        int          cur_len = 0;
        int          beat_idx = 0;
        bit          in_burst = 0;
        bit          pend = 0;
        logic [31:0] pend_addr = '0;
        logic [4:0]  pend_len = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_burst = 0;
                pend     = 0;
                beat_idx = 0;
            end else begin
                if (pend && !(mem_req_vld && mem_req_addr == pend_addr && mem_req_len == pend_len))
                    proto_err++;
                pend      = mem_req_vld && !mem_req_rdy;
                pend_addr = mem_req_addr;
                pend_len  = mem_req_len;
                if (mem_wd_vld && !in_burst) proto_err++;
                if (mem_req_vld && mem_req_rdy) begin
                    req_q.push_back('{addr: mem_req_addr, len: mem_req_len});
                    cur_len  = int'(mem_req_len);
                    beat_idx = 0;
                    in_burst = 1;
                end
                if (mem_wd_vld && mem_wd_rdy && in_burst) begin
                    bdata_q.push_back(mem_wd_data);
                    bstrb_q.push_back(mem_wd_strb);
                    blast_q.push_back(mem_wd_last);
                    if (mem_wd_last !== (beat_idx == cur_len - 1)) proto_err++;
                    beat_idx++;
                    if (beat_idx == cur_len) in_burst = 0;
                end
                if (dram_w_vld && dram_w_rdy) words_acc++;
                if (done) done_cnt++;
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        req_q.delete();
        bdata_q.delete();
        bstrb_q.delete();
        blast_q.delete();
        proto_err = 0;
        words_acc = 0;
    endtask

    task automatic start_layer(input logic [31:0] base);
        cfg_base_addr = base;
        cfg_start     = 1'b1;
        step();
        cfg_start     = 1'b0;
    endtask

    task automatic put_word(input logic [15:0] d, input bit last);
        bit ok;
        ok          = 0;
        dram_w_vld  = 1'b1;
        dram_w_data = d;
        dram_w_last = last;
        for (int c = 0; c < 2000 && !ok; c++) begin
            @(negedge clk);
            ok = dram_w_rdy;
            step();
        end
        dram_w_vld  = 1'b0;
        dram_w_last = 1'b0;
        chk("word_accept", ok, 1);
    endtask

    task automatic send_words(input int n, input logic [15:0] v0, input bit with_last);
        for (int i = 0; i < n; i++) put_word(v0 + 16'(i), with_last && (i == n - 1));
    endtask

    task automatic wait_done(input int exp, input string tag);
        for (int c = 0; c < 3000 && done_cnt < exp; c++) @(negedge clk);
        chk(tag, done_cnt, exp);
        step();
        step();
        chk({tag, "_single"}, done_cnt, exp);
        chk({tag, "_idle"}, busy, 0);
    endtask

    task automatic check_stream(input int n, input logic [15:0] v0, input string tag);
        int          nb;
        logic [63:0] ed;
        logic [7:0]  es;
        nb = (n + 3) / 4;
        chk({tag, "_nbeats"}, bdata_q.size(), nb);
        for (int b = 0; b < nb && b < bdata_q.size(); b++) begin
            ed = '0;
            es = '0;
            for (int l = 0; l < 4; l++) begin
                if (b * 4 + l < n) begin
                    ed[l*16 +: 16] = v0 + 16'(b * 4 + l);
                    es[l*2 +: 2]   = 2'b11;
                end
            end
            chk({tag, "_data"}, bdata_q[b], ed);
            chk({tag, "_strb"}, bstrb_q[b], es);
        end
    endtask

    initial begin
        int sum_len;

        // Reset state
        repeat (3) step();
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_w_rdy", dram_w_rdy, 0);
        chk("rst_req_vld", mem_req_vld, 0);
        chk("rst_req_addr", mem_req_addr, 0);
        chk("rst_req_len", mem_req_len, 0);
        chk("rst_wd_vld", mem_wd_vld, 0);
        chk("rst_wd_data", mem_wd_data, 0);
        chk("rst_wd_strb", mem_wd_strb, 0);
        chk("rst_wd_last", mem_wd_last, 0);
        step();
        rst = 1'b0;
        step();

        // T1: 8 words, one burst of two full beats
        clear_mon();
        start_layer(32'h1000);
        chk("t1_busy", busy, 1);
        send_words(8, 16'd1, 1);
        @(negedge clk);
        chk("t1_req_lat", mem_req_vld, 1);
        chk("t1_req_addr", mem_req_addr, 32'h1000);
        chk("t1_req_len", mem_req_len, 2);
        chk("t1_rdy_after_last", dram_w_rdy, 0);
        step();
        @(negedge clk);
        chk("t1_wd_lat", mem_wd_vld, 1);
        chk("t1_wd_first", mem_wd_data, 64'h0004_0003_0002_0001);
        wait_done(1, "t1_done");
        chk("t1_nreq", req_q.size(), 1);
        if (req_q.size() == 1) begin
            chk("t1_q_addr", req_q[0].addr, 32'h1000);
            chk("t1_q_len", req_q[0].len, 2);
        end
        chk("t1_nbeat", bdata_q.size(), 2);
        if (bdata_q.size() == 2) begin
            chk("t1_beat0", bdata_q[0], 64'h0004_0003_0002_0001);
            chk("t1_beat1", bdata_q[1], 64'h0008_0007_0006_0005);
            chk("t1_strb0", bstrb_q[0], 8'hFF);
            chk("t1_strb1", bstrb_q[1], 8'hFF);
            chk("t1_last0", blast_q[0], 0);
            chk("t1_last1", blast_q[1], 1);
        end
        chk("t1_proto", proto_err, 0);

        // T2: 70 words, a full burst then a two-beat burst with a partial tail
        clear_mon();
        start_layer(32'h0);
        send_words(70, 16'd1, 1);
        wait_done(2, "t2_done");
        chk("t2_nreq", req_q.size(), 2);
        if (req_q.size() == 2) begin
            chk("t2_addr0", req_q[0].addr, 32'h0);
            chk("t2_len0", req_q[0].len, 16);
            chk("t2_addr1", req_q[1].addr, 32'h80);
            chk("t2_len1", req_q[1].len, 2);
        end
        if (bdata_q.size() == 18) begin
            chk("t2_tail_data", bdata_q[17], 64'h0000_0000_0046_0045);
            chk("t2_tail_strb", bstrb_q[17], 8'h0F);
            chk("t2_last15", blast_q[15], 1);
            chk("t2_last17", blast_q[17], 1);
        end
        check_stream(70, 16'd1, "t2");
        chk("t2_proto", proto_err, 0);

        // T3: write data stalled until the beat FIFO fills
        clear_mon();
        mem_wd_rdy = 1'b0;
        start_layer(32'h100);
        fork
            send_words(160, 16'h200, 1);
            begin
                repeat (200) step();
                chk("t3_words_at_full", words_acc, 128);
                chk("t3_rdy_full", dram_w_rdy, 0);
                chk("t3_nreq_stall", req_q.size(), 1);
                chk("t3_nbeat_stall", bdata_q.size(), 0);
                mem_wd_rdy = 1'b1;
            end
        join
        wait_done(3, "t3_done");
        sum_len = 0;
        foreach (req_q[i]) sum_len += int'(req_q[i].len);
        chk("t3_sum_len", sum_len, 40);
        if (req_q.size() >= 2) begin
            chk("t3_addr0", req_q[0].addr, 32'h100);
            chk("t3_len0", req_q[0].len, 16);
            chk("t3_addr1", req_q[1].addr, 32'h180);
        end
        check_stream(160, 16'h200, "t3");
        chk("t3_proto", proto_err, 0);

        // T4: request held off for 10 cycles
        clear_mon();
        mem_req_rdy = 1'b0;
        start_layer(32'h3000);
        send_words(8, 16'h300, 1);
        for (int c = 0; c < 50 && !mem_req_vld; c++) step();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t4_req_vld", mem_req_vld, 1);
            chk("t4_req_addr", mem_req_addr, 32'h3000);
            chk("t4_req_len", mem_req_len, 2);
            chk("t4_no_wd", mem_wd_vld, 0);
            step();
        end
        mem_req_rdy = 1'b1;
        wait_done(4, "t4_done");
        chk("t4_nreq", req_q.size(), 1);
        check_stream(8, 16'h300, "t4");
        chk("t4_proto", proto_err, 0);

        // T5: reset while a burst is in its data phase
        clear_mon();
        mem_wd_rdy = 1'b0;
        start_layer(32'h1000);
        send_words(8, 16'h700, 1);
        for (int c = 0; c < 50 && !mem_wd_vld; c++) step();
        chk("t5_in_data", mem_wd_vld, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_w_rdy", dram_w_rdy, 0);
        chk("t5_req_vld", mem_req_vld, 0);
        chk("t5_req_addr", mem_req_addr, 0);
        chk("t5_req_len", mem_req_len, 0);
        chk("t5_wd_vld", mem_wd_vld, 0);
        chk("t5_wd_data", mem_wd_data, 0);
        chk("t5_wd_strb", mem_wd_strb, 0);
        chk("t5_wd_last", mem_wd_last, 0);
        step();
        clear_mon();
        mem_wd_rdy = 1'b1;
        repeat (5) step();
        chk("t5_quiet_req", req_q.size(), 0);
        chk("t5_quiet_beat", bdata_q.size(), 0);
        start_layer(32'h2000);
        send_words(4, 16'h400, 1);
        wait_done(5, "t5_done");
        chk("t5_nreq", req_q.size(), 1);
        if (req_q.size() == 1) begin
            chk("t5_addr", req_q[0].addr, 32'h2000);
            chk("t5_len", req_q[0].len, 1);
        end
        chk("t5_nbeat", bdata_q.size(), 1);
        if (bdata_q.size() == 1) chk("t5_beat", bdata_q[0], 64'h0403_0402_0401_0400);
        chk("t5_proto", proto_err, 0);

        // T6: word offered in IDLE, then cfg_start repeated mid-layer
        clear_mon();
        dram_w_vld  = 1'b1;
        dram_w_data = 16'hDEAD;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_idle_rdy", dram_w_rdy, 0);
            step();
        end
        dram_w_vld = 1'b0;
        chk("t6_idle_acc", words_acc, 0);
        start_layer(32'h4000);
        send_words(2, 16'h500, 0);
        start_layer(32'h5000);
        chk("t6_busy", busy, 1);
        chk("t6_no_req", req_q.size(), 0);
        send_words(2, 16'h502, 1);
        wait_done(6, "t6_done");
        chk("t6_nreq", req_q.size(), 1);
        if (req_q.size() == 1) begin
            chk("t6_addr", req_q[0].addr, 32'h4000);
            chk("t6_len", req_q[0].len, 1);
        end
        chk("t6_nbeat", bdata_q.size(), 1);
        if (bdata_q.size() == 1) begin
            chk("t6_beat", bdata_q[0], 64'h0503_0502_0501_0500);
            chk("t6_strb", bstrb_q[0], 8'hFF);
        end
        chk("t6_proto", proto_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
